// File: rtl/cam_pkg.sv
// Shared types and frame-store geometry for the camera frame writer.
// The frame store keeps every other pixel of every other line (2:1 decimation).
package cam_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } cam_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/cam_frame_writer_if.sv
// Camera byte stream in, frame-store write port out.
// The master side is the frame writer; the slave side is the camera/store.
interface cam_frame_writer_if #(
  parameter int ADDR_W = 17
);

  logic [7:0]        D;
  logic              href;
  logic              vsync;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              wr_en;

  modport master (
    input  D, href, vsync,
    output wr_addr, wr_data, wr_en
  );

  modport slave (
    output D, href, vsync,
    input  wr_addr, wr_data, wr_en
  );

endinterface

// File: rtl/rgb444_pack.sv
// Pairs the two camera bytes of a pixel into RGB444.
// pixel/pixel_valid are combinational on the phase-1 byte so the caller can register them.
module rgb444_pack
  import cam_pkg::*;
(
  input  logic       pclk,
  input  logic       reset_n,
  input  logic [7:0] D,
  input  logic       href,
  output rgb444_t    pixel,
  output logic       pixel_valid,
  output logic       phase_odd
);

  logic [3:0] r_q;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      phase_odd <= 1'b0;
      r_q       <= 4'd0;
    end else begin
      phase_odd <= href ? ~phase_odd : 1'b0;
      if (href && !phase_odd) r_q <= D[3:0];
    end
  end

  assign pixel       = {r_q, D[7:4], D[3:0]};
  assign pixel_valid = href & phase_odd;

endmodule

// File: rtl/cam_frame_writer.sv
// Writes a 2:1 decimated RGB444 image from a camera byte stream into a frame store.
//
// state   | meaning
// IDLE    | after reset, waiting for the first vsync so a partial frame is never stored
// SYNC    | vertical blanking; counters, address and line_err cleared
// CAPTURE | frame active, pixels at even x/y written to the store
// FROZEN  | frame active, store left untouched (freeze seen at frame start)
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 2 * FB_W,
  parameter int V_ACTIVE = 2 * FB_H,
  parameter int ADDR_W   = 17
) (
  input  logic                pclk,
  input  logic                reset_n,
  cam_frame_writer_if.master  bus,
  input  logic                freeze,
  output logic                frame_done,
  output logic                line_err,
  output logic [7:0]          frame_count
);

  localparam int DEPTH = (H_ACTIVE / 2) * (V_ACTIVE / 2);
  localparam int XW    = $clog2(H_ACTIVE + 1) + 1;
  localparam int YW    = $clog2(V_ACTIVE + 1) + 1;
  localparam logic [XW-1:0]     X_FULL   = XW'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(DEPTH);

  cam_state_t state, state_nxt;

  logic              vsync_d, href_d;
  logic              vsync_rise, href_fall;
  logic              in_frame, enter_sync, write_ok;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  rgb444_t           pixel;
  logic              pixel_valid, phase_odd;
  logic [ADDR_W-1:0] wr_addr_q;
  rgb444_t           wr_data_q;
  logic              wr_en_q;

  rgb444_pack u_pack (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .D           (bus.D),
    .href        (bus.href),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .phase_odd   (phase_odd)
  );

  assign vsync_rise = bus.vsync & ~vsync_d;
  assign href_fall  = href_d & ~bus.href;
  assign in_frame   = (state == CAPTURE) || (state == FROZEN);
  assign enter_sync = (state_nxt == SYNC) && (state != SYNC);

  // A vsync edge wins over a pixel completing in the same cycle.
  assign write_ok = (state == CAPTURE) && !vsync_rise && pixel_valid &&
                    !x_cnt[0] && !y_cnt[0] && (wr_addr_q < ADDR_END);

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:            if (bus.vsync) state_nxt = SYNC;
      SYNC:            if (!bus.vsync) state_nxt = freeze ? FROZEN : CAPTURE;
      CAPTURE, FROZEN: if (vsync_rise) state_nxt = SYNC;
      default:         state_nxt = IDLE;
    endcase
  end

  // Counters saturate so a runaway href cannot wrap back onto a valid count.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      vsync_d <= bus.vsync;
      href_d  <= bus.href;
      if (!in_frame) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (href_fall) begin
        x_cnt <= '0;
        if (y_cnt != '1) y_cnt <= y_cnt + 1'b1;
      end else if (pixel_valid && x_cnt != '1) begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      line_err    <= 1'b0;
    end else begin
      wr_en_q    <= write_ok;
      frame_done <= (state == CAPTURE) && vsync_rise;
      if (write_ok) wr_data_q <= pixel;
      if ((state == CAPTURE) && vsync_rise) frame_count <= frame_count + 8'd1;

      if (enter_sync)   wr_addr_q <= '0;
      else if (wr_en_q) wr_addr_q <= wr_addr_q + 1'b1;

      if (enter_sync)
        line_err <= 1'b0;
      else if (in_frame && href_fall && (x_cnt != X_FULL || phase_odd))
        line_err <= 1'b1;
    end
  end

  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_en   = wr_en_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Self-checking bench for cam_frame_writer on a reduced 16x8 camera geometry.
// Expected writes come from pixel coordinates and a running store counter kept by the bench.
module tb_cam_frame_writer;
  import cam_pkg::*;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int AW    = 17;
  localparam int DEPTH = (H / 2) * (V / 2);

  logic       pclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       freeze = 1'b0;
  logic       frame_done, line_err;
  logic [7:0] frame_count;

  cam_frame_writer_if #(.ADDR_W(AW)) bus ();

  cam_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .bus         (bus),
    .freeze      (freeze),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .frame_count (frame_count)
  );

  always #20 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_addr   = 0;
  bit m_capture = 0;
  bit m_active  = 0;
  bit m_err     = 0;
  int m_count   = 0;
  int act_wr    = 0;

  typedef struct {
    logic [7:0]  d0;
    logic [7:0]  d1;
    bit          exp_wr;
    logic [11:0] exp_data;
  } vec_t;

  vec_t tv [8];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit want_wr(input int x, input int y);
    return m_capture && (x % 2 == 0) && (y % 2 == 0) && (m_addr < DEPTH);
  endfunction

  task automatic cyc(input logic [7:0] d, input logic h, input logic v,
                     input bit exp_wr, input logic [11:0] exp_data, input bit exp_done);
    bus.D = d;
    bus.href = h;
    bus.vsync = v;
    @(posedge pclk);
    #1;
    check("wr_en", bus.wr_en, exp_wr);
    if (bus.wr_en) act_wr++;
    if (exp_wr) begin
      check("wr_addr", bus.wr_addr, m_addr);
      check("wr_data", bus.wr_data, exp_data);
      m_addr++;
    end
    check("frame_done", frame_done, exp_done);
    check("line_err", line_err, m_err);
    check("frame_count", frame_count, m_count);
  endtask

  task automatic vs_rise(input logic h, input logic [7:0] d);
    bit done;
    done = m_capture;
    if (m_capture) m_count = (m_count + 1) % 256;
    m_err = 0;
    m_capture = 0;
    m_active = 0;
    cyc(d, h, 1'b1, 1'b0, 12'h0, done);
    m_addr = 0;
  endtask

  task automatic vs_tail();
    cyc(8'h0, 1'b0, 1'b1, 1'b0, 12'h0, 1'b0);
    cyc(8'h0, 1'b0, 1'b1, 1'b0, 12'h0, 1'b0);
    cyc(8'h0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
    m_active = 1;
    m_capture = !freeze;
    act_wr = 0;
    repeat (2) cyc(8'h0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
  endtask

  task automatic vsync_pulse();
    vs_rise(1'b0, 8'h0);
    vs_tail();
  endtask

  // Sends one line; stop_at >= 0 cuts it at that byte, optionally with vsync rising there.
  task automatic line(input int y, input int nbytes, input int stop_at, input bit stop_vsync);
    logic [7:0] b0, d;
    b0 = 8'h0;
    for (int i = 0; i < nbytes; i++) begin
      d = 8'($urandom);
      if (i == stop_at) begin
        if (stop_vsync) vs_rise(1'b1, d);
        return;
      end
      if (i % 2 == 0) begin
        b0 = d;
        cyc(d, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
      end else begin
        cyc(d, 1'b1, 1'b0, want_wr(i / 2, y), {b0[3:0], d}, 1'b0);
      end
    end
    if (m_active && nbytes != 2 * H) m_err = 1;
    repeat (4) cyc(8'h0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
  endtask

  task automatic frame(input int n_lines, input int bad_y, input int bad_bytes);
    int nb, exp_w;
    vsync_pulse();
    exp_w = 0;
    for (int y = 0; y < n_lines; y++) begin
      nb = (y == bad_y) ? bad_bytes : 2 * H;
      if (y % 2 == 0) exp_w += (nb / 2 + 1) / 2;
      line(y, nb, -1, 1'b0);
    end
    if (!m_capture) exp_w = 0;
    if (exp_w > DEPTH) exp_w = DEPTH;
    check("frame_writes", act_wr, exp_w);
  endtask

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tv[0] = '{8'h0A, 8'h5C, 1'b1, 12'hA5C};
    tv[1] = '{8'h00, 8'h00, 1'b1, 12'h000};
    tv[2] = '{8'hFF, 8'hFF, 1'b1, 12'hFFF};
    tv[3] = '{8'hF3, 8'h12, 1'b1, 12'h312};
    tv[4] = '{8'h5A, 8'hA5, 1'b1, 12'hAA5};
    tv[5] = '{8'h80, 8'h01, 1'b1, 12'h001};
    tv[6] = '{8'h07, 8'hE8, 1'b1, 12'h7E8};
    tv[7] = '{8'hC9, 8'h3B, 1'b1, 12'h93B};

    bus.D = 8'h0;
    bus.href = 1'b0;
    bus.vsync = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_line_err", line_err, 0);
    check("rst_frame_count", frame_count, 0);
    reset_n = 1'b1;

    // Partial frame after reset is discarded, then two full frames captured.
    for (int y = 0; y < V; y++) line(y, 2 * H, -1, 1'b0);
    frame(V, -1, 0);
    frame(V, -1, 0);
    vsync_pulse();
    check("count_after_3_frames", frame_count, 2);
    check("line_err_clean", line_err, 0);

    // Byte-pairing vectors on line 0, filler pixels at odd x; then a short line at y=3.
    for (int k = 0; k < 8; k++) begin
      cyc(tv[k].d0, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
      cyc(tv[k].d1, 1'b1, 1'b0, tv[k].exp_wr, tv[k].exp_data, 1'b0);
      cyc(8'($urandom), 1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
      cyc(8'($urandom), 1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
    end
    repeat (4) cyc(8'h0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
    for (int y = 1; y < V; y++) line(y, (y == 3) ? 2 * (H - 1) : 2 * H, -1, 1'b0);
    check("short_line_frame_writes", act_wr, DEPTH);
    check("line_err_sticky", line_err, 1);

    // Odd byte count on one line plus extra lines beyond the store depth.
    frame(V + 3, 2, 2 * H + 1);
    check("addr_hold_at_depth", bus.wr_addr, DEPTH);
    check("line_err_odd_phase", line_err, 1);

    // Freeze raised mid-frame: this frame completes, the next is frozen.
    vsync_pulse();
    for (int y = 0; y < V; y++) begin
      if (y == 4) freeze = 1'b1;
      line(y, 2 * H, -1, 1'b0);
    end
    check("freeze_midframe_writes", act_wr, DEPTH);
    vsync_pulse();
    for (int y = 0; y < V; y++) begin
      if (y == 5) freeze = 1'b0;
      line(y, 2 * H, -1, 1'b0);
    end
    check("frozen_frame_writes", act_wr, 0);
    vsync_pulse();
    check("resume_start_addr", bus.wr_addr, 0);

    // vsync rises on the phase-1 byte of a writable pixel.
    line(0, 2 * H, -1, 1'b0);
    line(1, 2 * H, -1, 1'b0);
    line(2, 2 * H, 5, 1'b1);
    check("abort_addr_zero", bus.wr_addr, 0);
    vs_tail();
    for (int y = 0; y < V; y++) line(y, 2 * H, -1, 1'b0);
    check("after_abort_writes", act_wr, DEPTH);

    // Asynchronous reset in the middle of line 3.
    vsync_pulse();
    for (int y = 0; y < 3; y++) line(y, 2 * H, -1, 1'b0);
    line(3, 2 * H, 7, 1'b0);
    #5;
    reset_n = 1'b0;
    #1;
    check("async_rst_wr_en", bus.wr_en, 0);
    check("async_rst_wr_addr", bus.wr_addr, 0);
    check("async_rst_wr_data", bus.wr_data, 0);
    check("async_rst_frame_count", frame_count, 0);
    check("async_rst_line_err", line_err, 0);
    m_addr = 0;
    m_capture = 0;
    m_active = 0;
    m_err = 0;
    m_count = 0;
    @(posedge pclk);
    #1;
    reset_n = 1'b1;
    for (int y = 4; y < V; y++) line(y, 2 * H, -1, 1'b0);
    frame(V, -1, 0);

    // Randomized frames: freeze, malformed line position and length.
    for (int f = 0; f < 6; f++) begin
      int bad_len;
      freeze = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       bad_len = 2 * H - 2;
        1:       bad_len = 2 * H + 1;
        default: bad_len = 2 * H;
      endcase
      frame(V, $urandom_range(0, V - 1), bad_len);
    end
    freeze = 1'b0;
    vsync_pulse();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
